// File: rtl/scroll_scan_ctrl_pkg.sv
// scroll_scan_ctrl_pkg
// Shared types and constants for the scrolling student-number display sequencer.
//   state_e          : sequencer state (IDLE, RUN, PAUSE)
//   BLANK_DIGIT      : BCD code the segment decoder renders as an unlit digit
//   DEF_*            : default timing and geometry for a 50 MHz board
package scroll_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam int unsigned DEF_STEP_CYCLES = 25000000;  // 0.5 s scroll step
  localparam int unsigned DEF_SCAN_CYCLES = 50000;     // 1 ms per digit slot
  localparam int unsigned DEF_MSG_LEN     = 8;
  localparam int unsigned DEF_DISP_DIGITS = 4;

endpackage

// File: rtl/scroll_scan_ctrl_tick_gen.sv
// scroll_scan_ctrl_tick_gen
// Prescaler counting 0..CYCLES-1 while enabled, producing a one-cycle tick on the
// last count. Holds its count when disabled.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   i_en    : count enable
//   i_clr   : synchronous clear, overrides i_en
//   o_tick  : high while enabled and the count sits at CYCLES-1
module scroll_scan_ctrl_tick_gen #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick    = i_en & w_at_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/scroll_scan_ctrl.sv
// scroll_scan_ctrl
// Scrolls an MSG_LEN-digit message through a DISP_DIGITS-wide multiplexed 7-segment
// window. A slow step prescaler advances the scroll offset; a fast scan prescaler
// rotates the enabled digit.
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, (re)start scrolling from offset 0
//   pause           : level, freeze scrolling (scan keeps running)
//   loop            : level, 1 = wrap after last step, 0 = one-shot
//   wr_en/addr/data : message buffer write port, honoured only in IDLE
//   an              : active-low digit enables
//   digit           : BCD value for the enabled digit (BLANK_DIGIT = off)
//   pos             : current scroll offset
//   busy            : high in RUN or PAUSE
//   done            : one-cycle pulse when a one-shot scroll finishes
module scroll_scan_ctrl
  import scroll_scan_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned SCAN_CYCLES = DEF_SCAN_CYCLES,
  parameter int unsigned MSG_LEN     = DEF_MSG_LEN,
  parameter int unsigned DISP_DIGITS = DEF_DISP_DIGITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       loop,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [DISP_DIGITS-1:0]     an,
  output logic [3:0]                 digit,
  output logic [$clog2(MSG_LEN)-1:0] pos,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned PW    = $clog2(MSG_LEN);
  localparam int unsigned SEL_W = $clog2(DISP_DIGITS);
  // Wide enough to hold pos + scan_sel without overflow.
  localparam int unsigned IW    = PW + SEL_W;

  localparam logic [PW-1:0]    POS_LAST = PW'(MSG_LEN - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DISP_DIGITS - 1);
  localparam logic [PW:0]      LEN_W    = (PW + 1)'(MSG_LEN);
  localparam logic [IW-1:0]    LEN_I    = IW'(MSG_LEN);

  state_e              r_state;
  logic [PW-1:0]       r_pos;
  logic                r_busy;
  logic                r_done;
  logic [SEL_W-1:0]    r_scan_sel;
  logic [3:0]          r_buf [MSG_LEN];
  logic [DISP_DIGITS-1:0] r_an;
  logic [3:0]          r_digit;

  logic                w_step_en;
  logic                w_step_clr;
  logic                w_step_tick;
  logic                w_scan_tick;
  logic                w_final_step;
  logic                w_wr_ok;
  logic [IW-1:0]       w_win_idx;
  logic                w_win_valid;
  logic [3:0]          w_digit_next;

  // Step prescaler only advances in RUN; IDLE keeps it cleared so every run starts
  // from a full step period.
  assign w_step_en  = (r_state == RUN);
  assign w_step_clr = start | (r_state == IDLE);

  scroll_scan_ctrl_tick_gen #(
    .CYCLES (STEP_CYCLES)
  ) u_step_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_step_en),
    .i_clr  (w_step_clr),
    .o_tick (w_step_tick)
  );

  scroll_scan_ctrl_tick_gen #(
    .CYCLES (SCAN_CYCLES)
  ) u_scan_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .i_clr  (1'b0),
    .o_tick (w_scan_tick)
  );

  assign w_final_step = w_step_tick & (r_pos == POS_LAST) & ~loop;

  // Sequencer: start wins over everything, including a same-cycle pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state <= RUN;
        r_pos   <= '0;
        r_busy  <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          RUN: begin
            if (w_final_step) begin
              r_pos   <= '0;
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              if (w_step_tick) begin
                r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
              end
              if (pause) begin
                r_state <= PAUSE;
              end
            end
          end
          PAUSE: begin
            if (!pause) begin
              r_state <= RUN;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Writes are only accepted while idle, so the visible message never tears mid-scroll.
  assign w_wr_ok = wr_en & (r_state == IDLE) & ({1'b0, wr_addr} < LEN_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MSG_LEN); i++) begin
        r_buf[i] <= BLANK_DIGIT;
      end
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_sel <= '0;
    end else if (w_scan_tick) begin
      r_scan_sel <= (r_scan_sel == SEL_LAST) ? '0 : r_scan_sel + 1'b1;
    end
  end

  // The window does not wrap into the buffer start: slots past the end are blank.
  assign w_win_idx   = IW'(r_pos) + IW'(r_scan_sel);
  assign w_win_valid = (w_win_idx < LEN_I);

  always_comb begin
    w_digit_next = BLANK_DIGIT;
    if (w_win_valid) begin
      w_digit_next = r_buf[w_win_idx[PW-1:0]];
    end
  end

  // an and digit share one register stage so they always describe the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= ~(DISP_DIGITS)'(1);
      r_digit <= BLANK_DIGIT;
    end else begin
      r_an    <= ~((DISP_DIGITS)'(1) << r_scan_sel);
      r_digit <= w_digit_next;
    end
  end

  assign an    = r_an;
  assign digit = r_digit;
  assign pos   = r_pos;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
